// File: rtl/varredura_servo.sv
// varredura_servo: servo sweep sequencer stepping a 3-bit position, driving PWM and a dwell-end strobe
// Ports:
//   clock        single clock
//   reset        asynchronous active-high reset
//   ligar        sweep enable; at 0 position, direction and dwell progress freeze
//   posicao      current position index (angle ROM address)
//   sentido      sweep direction, 1 = ascending
//   pwm          servo control pulse, registered
//   fim_posicao  one-cycle registered strobe on the last cycle of each dwell
// Build option: define VARREDURA_SERRA_EN for a sawtooth sweep (0..7,0..7) instead of triangular.
module varredura_servo #(
  parameter int PERIODO_PWM          = 1_000_000,
  parameter int LARGURA_BASE         = 55_000,
  parameter int PASSO_LARGURA        = 11_000,
  parameter int PERIODOS_POR_POSICAO = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  output logic [2:0] posicao,
  output logic       sentido,
  output logic       pwm,
  output logic       fim_posicao
);
  localparam int W  = $clog2(PERIODO_PWM);
  localparam int PW = (PERIODOS_POR_POSICAO > 1) ? $clog2(PERIODOS_POR_POSICAO) : 1;
  localparam logic [W-1:0]  ULTIMO    = W'(PERIODO_PWM - 1);
  localparam logic [W-1:0]  PENULTIMO = W'(PERIODO_PWM - 2);
  localparam logic [W-1:0]  BASE      = W'(LARGURA_BASE);
  localparam logic [W-1:0]  PASSO     = W'(PASSO_LARGURA);
  localparam logic [PW-1:0] PER_ULT   = PW'(PERIODOS_POR_POSICAO - 1);
  logic [W-1:0]  contador, largura, largura_nova, largura_atual;
  logic [PW-1:0] periodos;
  logic [2:0]    pos_prox;
  logic          ativo, fim_periodo, vespera, sentido_prox;
  // The width is refreshed at counter 0 from the current position, so a step
  // made at the period end takes effect from the very first cycle of the new period.
  always_comb begin
    fim_periodo   = contador == ULTIMO;
    vespera       = contador == PENULTIMO;
    largura_nova  = BASE + W'(posicao) * PASSO;
    largura_atual = (contador == '0) ? largura_nova : largura;
`ifdef VARREDURA_SERRA_EN
    pos_prox      = posicao + 3'd1;
    sentido_prox  = 1'b1;
`else
    pos_prox      = sentido ? posicao + 3'd1 : posicao - 3'd1;
    sentido_prox  = sentido ? (pos_prox != 3'd7) : (pos_prox == 3'd0);
`endif
  end
  // ligar is captured one cycle before the period end so the registered strobe
  // and the period/position update at that end act on the same decision.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      contador    <= '0;
      largura     <= BASE;
      pwm         <= 1'b0;
      ativo       <= 1'b0;
      periodos    <= '0;
      fim_posicao <= 1'b0;
      posicao     <= 3'd0;
      sentido     <= 1'b1;
    end else begin
      contador    <= fim_periodo ? '0 : contador + 1'b1;
      largura     <= largura_atual;
      pwm         <= contador < largura_atual;
      ativo       <= vespera ? ligar : ativo;
      fim_posicao <= vespera && ligar && (periodos == PER_ULT);
      if (fim_posicao) begin
        periodos <= '0;
        posicao  <= pos_prox;
        sentido  <= sentido_prox;
      end else if (fim_periodo && ativo) begin
        periodos <= periodos + 1'b1;
      end
    end
endmodule
